conv_sram_rw_pipe: RTL and testbench
====================================

Name: conv_sram_rw_pipe

Overview:
- Parametrised single-port read/write SRAM model. It is the successor to the fixed 16x288 per-layer convolution buffers.
- New capabilities over those buffers:
  - per-lane write mask
  - configurable read latency with a dout-valid strobe
  - non-power-of-two depth with out-of-range detection
  - hardware clear sweep after reset or on request
- Sits between the DNN layer controllers and on-chip weight/feature storage, one instance per buffer.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of LANE_WIDTH.
- DEPTH, 288, number of words; any value >= 2.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- LANE_WIDTH, 8, bits per write-mask lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- READ_LATENCY, 1, cycles from accepted read to dout0_valid; legal range 1..4.
- CLEAR_VALUE, 0, word value written by the clear sweep.

Ports:
- clk0  in  1  clock; all activity on the rising edge.
- rst0_n  in  1  asynchronous active-low reset.
- csb0  in  1  active-low chip select.
- web0  in  1  active-low write enable.
- wmask0  in  NUM_LANES  per-lane write enable; bit i covers din0[i*LANE_WIDTH +: LANE_WIDTH].
- addr0  in  ADDR_WIDTH  word address.
- din0  in  DATA_WIDTH  write data.
- clear0  in  1  request a full clear sweep.
- ready0  out  1  high when requests are accepted.
- dout0  out  DATA_WIDTH  read data.
- dout0_valid  out  1  one-cycle strobe, dout0 valid.
- addr_err0  out  1  strobe, aligned with dout0_valid for reads or next cycle for writes, when addr0 >= DEPTH.

Behaviour:
- Reset (rst0_n low, asynchronous):
  - outputs: ready0=0, dout0=0, dout0_valid=0, addr_err0=0.
  - read pipeline flushed; FSM goes to CLEAR with sweep counter 0.
  - the array itself is not reset.
- FSM states:
  - CLEAR: writes CLEAR_VALUE to address cnt each cycle, cnt increments. When cnt == DEPTH-1 is written, next state is IDLE. ready0=0.
  - IDLE: ready0=1. clear0=1 sampled high moves to CLEAR next cycle with cnt=0.
- Sweep timing: a clear takes exactly DEPTH cycles. ready0 rises on the cycle after the last sweep write.
- Request acceptance: a request is accepted at a rising edge with ready0=1 and csb0=0. Requests while ready0=0 are ignored silently, with no error.
- Write (web0=0):
  - lanes with wmask0[i]=1 updated at the accepting edge; other lanes unchanged.
  - wmask0 all-zero is a legal no-op.
- Read (web0=1):
  - mem[addr0] sampled at the accepting edge.
  - dout0/dout0_valid appear exactly READ_LATENCY edges later.
  - back-to-back reads give back-to-back valid strobes (full throughput).
- Hold: dout0 holds its last valid value when dout0_valid=0; it never goes X.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- Out-of-range (addr0 >= DEPTH):
  - write: array untouched, addr_err0 pulses the next cycle.
  - read: dout0=0 with dout0_valid=1 and addr_err0=1 at normal latency.
- clear0 together with an accepted request: the request completes normally, then CLEAR starts. Reads in flight still deliver at normal latency during CLEAR.
- clear0 while already in CLEAR: ignored; the sweep is not restarted.
- Reset mid-sweep or mid-read: pending strobes are dropped and the sweep restarts from 0 after rst0_n deasserts.

Optional Feature:
- Macro: CONV_SRAM_PARITY_EN.
- When defined:
  - the array stores one even-parity bit per lane, computed from the written data.
  - on each read, parity is rechecked.
  - extra output parity_err0 (1 bit, reset 0) pulses with dout0_valid if any lane mismatches.
  - clear sweep writes consistent parity.
  - test-only input parity_flip0 (NUM_LANES) inverts stored parity on the next write.
- When undefined: no parity storage, no parity_err0 or parity_flip0 ports.

Decomposition:
- Package conv_sram_pkg holds:
  - the FSM state enum (ST_CLEAR, ST_IDLE)
  - function lane_parity
  - constant MAX_READ_LATENCY=4
- One natural sub-module: conv_sram_rd_pipe, a READ_LATENCY-deep shift register carrying data, valid, addr_err and parity_err, with async reset of its valid bits.

Test Plan:
- Reset release → ready0 stays 0 for exactly 288 cycles. Reads of addresses 0, 143 and 287 then return 0x0000.
- Write 0xA5C3 to addr 5 with wmask0=2'b11, then wmask0=2'b01 writing 0xFFFF → read addr 5 returns 0xA5FF, dout0_valid exactly READ_LATENCY cycles after acceptance (check READ_LATENCY=1 and 3).
- 16 back-to-back reads of addrs 0..15 after writing data=addr*3 → 16 consecutive valid strobes with values 0,3,…,45.
- Write addr 300 and read addr 511 → array unchanged, addr_err0 pulses each time, read dout0=0.
- clear0 asserted together with a read of addr 5 holding 0x1234 → read returns 0x1234, ready0 drops for 288 cycles, addr 5 then reads 0.
- CONV_SRAM_PARITY_EN defined: write 0x00FF with parity_flip0=2'b01, read back → parity_err0=1. Rewrite without flip and read → parity_err0=0.

Source files
------------

// File: rtl/conv_sram_pkg.sv
// conv_sram_pkg: shared types and helpers for the conv_sram_rw_pipe buffer.
//   sram_state_e      - controller state (clear sweep or idle/accepting)
//   MAX_READ_LATENCY  - deepest supported read pipeline
//   lane_parity()     - even-parity bit of one write-mask lane
package conv_sram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } sram_state_e;

    localparam int MAX_READ_LATENCY = 4;

    // Lanes are zero-extended into this width before parity is taken;
    // the extension bits do not change the XOR.
    localparam int MAX_LANE_WIDTH = 64;

    function automatic logic lane_parity(input logic [MAX_LANE_WIDTH-1:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/conv_sram_rd_pipe.sv
// conv_sram_rd_pipe: LATENCY-deep read-return shift register.
//   clk0, rst0_n        clock, asynchronous active-low reset
//   rd_valid/rd_data    read accepted this edge and the word sampled from the array
//   rd_flags            per-read status bits (address error, optional parity error)
//   dout_valid/dout     delivered word; dout holds its last valid value
//   dout_flags          status bits aligned with dout_valid (zero otherwise)
module conv_sram_rd_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int FLAG_W     = 1,
    parameter int LATENCY    = 1
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [FLAG_W-1:0]     rd_flags,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [FLAG_W-1:0]     dout_flags
);

    genvar gi;
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic                  valid_reg;
        logic [DATA_WIDTH-1:0] data_reg;
        logic [FLAG_W-1:0]     flags_reg;
        logic                  prev_valid;
        logic [DATA_WIDTH-1:0] prev_data;
        logic [FLAG_W-1:0]     prev_flags;

        if (gi == 0) begin : g_head
            assign prev_valid = rd_valid;
            assign prev_data  = rd_data;
            assign prev_flags = rd_flags;
        end else begin : g_body
            assign prev_valid = g_stage[gi-1].valid_reg;
            assign prev_data  = g_stage[gi-1].data_reg;
            assign prev_flags = g_stage[gi-1].flags_reg;
        end

        // Data only moves with a valid token, so the last stage keeps the
        // most recent delivered word between strobes.
        always_ff @(posedge clk0 or negedge rst0_n) begin
            if (!rst0_n) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
                flags_reg <= '0;
            end else begin
                valid_reg <= prev_valid;
                flags_reg <= prev_valid ? prev_flags : '0;
                if (prev_valid) begin
                    data_reg <= prev_data;
                end
            end
        end
    end

    assign dout_valid = g_stage[LATENCY-1].valid_reg;
    assign dout       = g_stage[LATENCY-1].data_reg;
    assign dout_flags = g_stage[LATENCY-1].flags_reg;

endmodule

// File: rtl/conv_sram_rw_pipe.sv
// conv_sram_rw_pipe: single-port read/write SRAM with per-lane write mask,
// configurable read latency, out-of-range detection and a clear sweep.
//   clk0, rst0_n   clock, asynchronous active-low reset (array not reset)
//   csb0, web0     active-low chip select / write enable
//   wmask0         per-lane write enables, addr0 word address, din0 write data
//   clear0         request a full clear sweep (sampled while idle)
//   ready0         requests accepted when high
//   dout0, dout0_valid  read data and its one-cycle strobe
//   addr_err0      out-of-range strobe (with dout0_valid for reads, next cycle for writes)
// Optional build macro CONV_SRAM_PARITY_EN adds per-lane even parity storage,
// input parity_flip0 (inverts stored parity of written lanes) and output parity_err0.
module conv_sram_rw_pipe
    import conv_sram_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    DEPTH        = 288,
    parameter int                    ADDR_WIDTH   = $clog2(DEPTH),
    parameter int                    LANE_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                             clk0,
    input  logic                             rst0_n,
    input  logic                             csb0,
    input  logic                             web0,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]            addr0,
    input  logic [DATA_WIDTH-1:0]            din0,
    input  logic                             clear0,
`ifdef CONV_SRAM_PARITY_EN
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] parity_flip0,
    output logic                             parity_err0,
`endif
    output logic                             ready0,
    output logic [DATA_WIDTH-1:0]            dout0,
    output logic                             dout0_valid,
    output logic                             addr_err0
);

    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    // Out-of-range latencies are clamped to the supported window.
    localparam int PIPE_LATENCY = (READ_LATENCY < 1) ? 1 :
                                  (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                  READ_LATENCY;

    sram_state_e             state_reg;
    logic [ADDR_WIDTH-1:0]   cnt_reg;
    logic                    ready_reg;
    logic                    wr_err_reg;

    logic                    accept;
    logic                    in_range;
    logic                    rd_fire;
    logic                    wr_fire;
    logic                    sweep;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Acceptance only happens in IDLE, so a sweep write and a request
    // write can never collide on the single port.
    assign accept   = ready_reg & ~csb0;
    assign in_range = {1'b0, addr0} < (ADDR_WIDTH + 1)'(DEPTH);
    assign rd_fire  = accept & web0;
    assign wr_fire  = accept & ~web0 & in_range;
    assign sweep    = (state_reg == ST_CLEAR);
    assign ram_addr = sweep ? cnt_reg : addr0;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_reg  <= ST_CLEAR;
            cnt_reg    <= '0;
            ready_reg  <= 1'b0;
            wr_err_reg <= 1'b0;
        end else begin
            wr_err_reg <= accept & ~web0 & ~in_range;
            case (state_reg)
                ST_CLEAR: begin
                    if (cnt_reg == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_reg <= ST_IDLE;
                        ready_reg <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clear0) begin
                        state_reg <= ST_CLEAR;
                        ready_reg <= 1'b0;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_CLEAR;
                    ready_reg <= 1'b0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

`ifdef CONV_SRAM_PARITY_EN
    localparam int FLAG_W = 2;
    logic [NUM_LANES-1:0] rd_perr;
`else
    localparam int FLAG_W = 1;
`endif

    // One storage array per lane so each lane's write enable is independent.
    genvar gi;
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [LANE_WIDTH-1:0] mem [DEPTH];
        logic                  wr_en;
        logic [LANE_WIDTH-1:0] wr_lane;

        assign wr_en   = sweep | (wr_fire & wmask0[gi]);
        assign wr_lane = sweep ? CLEAR_VALUE[gi*LANE_WIDTH +: LANE_WIDTH]
                               : din0[gi*LANE_WIDTH +: LANE_WIDTH];

        always_ff @(posedge clk0) begin
            if (wr_en) begin
                mem[ram_addr] <= wr_lane;
            end
        end

        // Out-of-range reads return zero instead of an undefined array word.
        assign rd_word[gi*LANE_WIDTH +: LANE_WIDTH] = in_range ? mem[addr0] : '0;

`ifdef CONV_SRAM_PARITY_EN
        logic par_mem [DEPTH];

        always_ff @(posedge clk0) begin
            if (wr_en) begin
                par_mem[ram_addr] <= sweep ? lane_parity(MAX_LANE_WIDTH'(wr_lane))
                                           : lane_parity(MAX_LANE_WIDTH'(wr_lane)) ^ parity_flip0[gi];
            end
        end

        assign rd_perr[gi] = in_range &
            (par_mem[addr0] != lane_parity(MAX_LANE_WIDTH'(rd_word[gi*LANE_WIDTH +: LANE_WIDTH])));
`endif
    end

    logic [FLAG_W-1:0] rd_flags;
    logic [FLAG_W-1:0] dout_flags;

`ifdef CONV_SRAM_PARITY_EN
    assign rd_flags    = {|rd_perr, ~in_range};
    assign parity_err0 = dout_flags[1];
`else
    assign rd_flags    = ~in_range;
`endif

    // The first pipe stage is the registered read of the array.
    conv_sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .FLAG_W     (FLAG_W),
        .LATENCY    (PIPE_LATENCY)
    ) u_rd_pipe (
        .clk0       (clk0),
        .rst0_n     (rst0_n),
        .rd_valid   (rd_fire),
        .rd_data    (rd_word),
        .rd_flags   (rd_flags),
        .dout_valid (dout0_valid),
        .dout       (dout0),
        .dout_flags (dout_flags)
    );

    assign ready0    = ready_reg;
    assign addr_err0 = dout_flags[0] | wr_err_reg;

endmodule

// File: tb/tb_conv_sram_rw_pipe.sv
// Testbench for conv_sram_rw_pipe: two instances (READ_LATENCY 1 and 3)
// driven with identical stimulus; a scoreboard per instance holds expected
// read returns, compared whenever that instance strobes dout0_valid.
module tb_conv_sram_rw_pipe;

    localparam int DW    = 16;
    localparam int DEPTH = 288;
    localparam int AW    = 9;

    logic          clk0   = 1'b0;
    logic          rst0_n = 1'b0;
    logic          csb0   = 1'b1;
    logic          web0   = 1'b1;
    logic          clear0 = 1'b0;
    logic [1:0]    wmask0 = '0;
    logic [AW-1:0] addr0  = '0;
    logic [DW-1:0] din0   = '0;
    logic [1:0]    flip   = '0;

    logic          ready [2];
    logic          valid [2];
    logic          aerr  [2];
    logic [DW-1:0] dout  [2];
`ifdef CONV_SRAM_PARITY_EN
    logic          perr  [2];
`endif

    always #5 clk0 = ~clk0;

    int cyc = 0;
    always @(posedge clk0) cyc <= cyc + 1;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_dut
        conv_sram_rw_pipe #(
            .DATA_WIDTH   (DW),
            .DEPTH        (DEPTH),
            .ADDR_WIDTH   (AW),
            .LANE_WIDTH   (8),
            .READ_LATENCY (1 + 2 * gi),
            .CLEAR_VALUE  (16'h0000)
        ) dut (
            .clk0         (clk0),
            .rst0_n       (rst0_n),
            .csb0         (csb0),
            .web0         (web0),
            .wmask0       (wmask0),
            .addr0        (addr0),
            .din0         (din0),
            .clear0       (clear0),
`ifdef CONV_SRAM_PARITY_EN
            .parity_flip0 (flip),
            .parity_err0  (perr[gi]),
`endif
            .ready0       (ready[gi]),
            .dout0        (dout[gi]),
            .dout0_valid  (valid[gi]),
            .addr_err0    (aerr[gi])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        perr;
        int          acc;
    } exp_t;

    exp_t        sb [2][$];
    int          werr_q[$];
    logic [15:0] model [DEPTH];
    logic [1:0]  pbad  [DEPTH];
    logic [15:0] last  [2];
    bit          mon_en = 0;

    // Latency is counted as cycles from the accepting edge until the strobe
    // is sampled: READ_LATENCY 1 means valid in the cycle after acceptance.
    always @(negedge clk0) begin : monitor
        exp_t e;
        logic exp_e;
        logic exp_pe;
        logic werr_now;
        if (mon_en) begin
            werr_now = (werr_q.size() > 0) && (werr_q[0] == cyc);
            for (int d = 0; d < 2; d++) begin
                exp_e  = werr_now;
                exp_pe = 1'b0;
                if (valid[d]) begin
                    if (sb[d].size() == 0) begin
                        chk($sformatf("unexpected_valid_L%0d", 1 + 2 * d), 1, 0);
                    end else begin
                        e = sb[d].pop_front();
                        chk($sformatf("rd_data_L%0d", 1 + 2 * d), 32'(dout[d]), 32'(e.data));
                        chk($sformatf("rd_latency_L%0d", 1 + 2 * d), 32'(cyc - e.acc + 1), 32'(1 + 2 * d));
                        exp_e  = exp_e | e.err;
                        exp_pe = e.perr;
                    end
                    last[d] = dout[d];
                end else begin
                    chk($sformatf("dout_hold_L%0d", 1 + 2 * d), 32'(dout[d]), 32'(last[d]));
                end
                if (aerr[d] || exp_e)
                    chk($sformatf("addr_err_L%0d", 1 + 2 * d), 32'(aerr[d]), 32'(exp_e));
`ifdef CONV_SRAM_PARITY_EN
                if (perr[d] || exp_pe)
                    chk($sformatf("parity_err_L%0d", 1 + 2 * d), 32'(perr[d]), 32'(exp_pe));
`endif
            end
            if (werr_now) void'(werr_q.pop_front());
        end
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 16'h0000;
            pbad[i]  = 2'b00;
        end
    endtask

    // One request driven on a negedge; accepted at the following posedge.
    task automatic req(input logic we_n, input logic [AW-1:0] a, input logic [15:0] d,
                       input logic [1:0] m, input logic clr, input logic [1:0] fl);
        exp_t e;
        @(negedge clk0);
        csb0 = 1'b0; web0 = we_n; addr0 = a; din0 = d; wmask0 = m; clear0 = clr; flip = fl;
        if (we_n) begin
            e.data = (a < DEPTH) ? model[a] : 16'h0000;
            e.err  = (a >= DEPTH);
            e.perr = (a < DEPTH) ? (|pbad[a]) : 1'b0;
            e.acc  = cyc + 1;
            sb[0].push_back(e);
            sb[1].push_back(e);
        end else if (a >= DEPTH) begin
            werr_q.push_back(cyc + 1);
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m[i]) begin
                    model[a][i*8 +: 8] = d[i*8 +: 8];
                    pbad[a][i] = fl[i];
                end
            end
        end
        if (clr) model_clear();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
        req(1'b0, a, d, m, 1'b0, 2'b00);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        req(1'b1, a, 16'h0000, 2'b00, 1'b0, 2'b00);
    endtask

    task automatic idle();
        @(negedge clk0);
        csb0 = 1'b1; web0 = 1'b1; clear0 = 1'b0; wmask0 = '0; flip = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int n;
        last[0] = '0;
        last[1] = '0;
        repeat (3) @(negedge clk0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready_L%0d", 1 + 2 * d), 32'(ready[d]), 0);
            chk($sformatf("rst_dout_L%0d", 1 + 2 * d), 32'(dout[d]), 0);
            chk($sformatf("rst_valid_L%0d", 1 + 2 * d), 32'(valid[d]), 0);
            chk($sformatf("rst_addr_err_L%0d", 1 + 2 * d), 32'(aerr[d]), 0);
        end

        // Power-up sweep length.
        model_clear();
        mon_en = 1;
        rst0_n = 1'b1;
        n = 0;
        while (!ready[0] && n < 2000) begin
            @(negedge clk0);
            n++;
        end
        chk("reset_sweep_cycles", 32'(n), 288);
        chk("reset_sweep_ready_L3", 32'(ready[1]), 1);

        rd(9'd0); rd(9'd143); rd(9'd287);

        // Lane masking and read-after-write.
        wr(9'd5, 16'hA5C3, 2'b11);
        wr(9'd5, 16'hFFFF, 2'b01);
        rd(9'd5);

        // Back-to-back reads.
        for (int i = 0; i < 16; i++) wr(AW'(i), 16'(i * 3), 2'b11);
        for (int i = 0; i < 16; i++) rd(AW'(i));

        // Out-of-range write and read; aliasing addresses stay untouched.
        wr(9'd300, 16'hDEAD, 2'b11);
        rd(9'd511);
        rd(9'd12);
        rd(9'd44);
        idle();

        // Read together with clear0, then sweep with ignored requests inside.
        wr(9'd5, 16'h1234, 2'b11);
        req(1'b1, 9'd5, 16'h0000, 2'b00, 1'b1, 2'b00);
        idle();
        n = 0;
        while (!ready[0] && n < 2000) begin
            csb0 = 1'b1; clear0 = 1'b0;
            if (n == 50) begin
                csb0 = 1'b0; web0 = 1'b1; addr0 = 9'd7;
            end else if (n == 100) begin
                clear0 = 1'b1;
            end
            @(negedge clk0);
            n++;
        end
        csb0 = 1'b1; clear0 = 1'b0;
        chk("clear_req_sweep_cycles", 32'(n), 288);
        rd(9'd5);
        rd(9'd143);

`ifdef CONV_SRAM_PARITY_EN
        req(1'b0, 9'd5, 16'h00FF, 2'b11, 1'b0, 2'b01);
        rd(9'd5);
        wr(9'd5, 16'h00FF, 2'b11);
        rd(9'd5);
`endif

        repeat (8) idle();
        chk("sb_drained_L1", 32'(sb[0].size()), 0);
        chk("sb_drained_L3", 32'(sb[1].size()), 0);
        chk("werr_drained", 32'(werr_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
